// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared constants and requantization helpers for the MAC / dot-product datapath.
//   DEF_*      : default parameter values for mac_dot_product
//   PKG_W      : width of the signed container the helpers operate on
//   sat_res_t  : {sat, data} result of sat_shift
//   round_shift: optional round-half-up followed by arithmetic right shift
//   sat_shift  : round_shift followed by clamping to a signed out_w range
// Callers sign-extend their value into PKG_W bits. Accumulators up to
// PKG_W-2 bits leave headroom for the rounding add, so it cannot overflow.
// -----------------------------------------------------------------------------
package mac_pkg;

  localparam int unsigned DEF_DATA_W   = 32'd8;
  localparam int unsigned DEF_ACC_W    = 32'd24;
  localparam int unsigned DEF_OUT_W    = 32'd16;
  localparam int unsigned DEF_SHIFT    = 32'd0;
  localparam int unsigned DEF_ROUND    = 32'd0;
  localparam int unsigned DEF_SATURATE = 32'd1;

  localparam int unsigned PKG_W = 32'd64;

  typedef struct packed {
    logic                    sat;
    logic signed [PKG_W-1:0] data;
  } sat_res_t;

  // Round half up (when requested and shift > 0), then arithmetic shift right.
  function automatic logic signed [PKG_W-1:0] round_shift(
    input logic signed [PKG_W-1:0] value,
    input int unsigned             shift,
    input logic                    round
  );
    logic signed [PKG_W-1:0] r;
    if (round && (shift > 32'd0)) begin
      r = value + (64'sd1 <<< (shift - 32'd1));
    end else begin
      r = value;
    end
    return r >>> shift;
  endfunction

  // Requantize and clamp into the signed out_w range; sat flags a clamp.
  function automatic sat_res_t sat_shift(
    input logic signed [PKG_W-1:0] value,
    input int unsigned             shift,
    input logic                    round,
    input int unsigned             out_w
  );
    logic signed [PKG_W-1:0] s;
    logic signed [PKG_W-1:0] hi;
    logic signed [PKG_W-1:0] lo;
    sat_res_t                res;
    s  = round_shift(value, shift, round);
    hi = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 32'd1));
    if (s > hi) begin
      res.sat  = 1'b1;
      res.data = hi;
    end else if (s < lo) begin
      res.sat  = 1'b1;
      res.data = lo;
    end else begin
      res.sat  = 1'b0;
      res.data = s;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// -----------------------------------------------------------------------------
// mac_mult_stage
// Two-register signed multiplier with a valid/last sidechain (S1: operand
// capture, S2: full-width product). Kept as its own block so it can be swapped
// for a DSP-inferred or vendor multiplier with the same latency.
//   i_clk, i_rst (sync, active high), i_clr (sync abort of in-flight pairs)
//   i_valid/i_last/i_a/i_b : operand pair in
//   o_valid/o_last/o_p     : registered product out, 2*DATA_W bits
// -----------------------------------------------------------------------------
module mac_mult_stage
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clr,
  input  logic                       i_valid,
  input  logic                       i_last,
  input  logic signed [DATA_W-1:0]   i_a,
  input  logic signed [DATA_W-1:0]   i_b,
  output logic                       o_valid,
  output logic                       o_last,
  output logic signed [2*DATA_W-1:0] o_p
);

  logic                       r_s1_valid;
  logic                       r_s1_last;
  logic signed [DATA_W-1:0]   r_s1_a;
  logic signed [DATA_W-1:0]   r_s1_b;
  logic                       r_s2_valid;
  logic                       r_s2_last;
  logic signed [2*DATA_W-1:0] r_s2_p;

  logic signed [2*DATA_W-1:0] w_a_ext;
  logic signed [2*DATA_W-1:0] w_b_ext;
  logic signed [2*DATA_W-1:0] w_prod;

  // Full-width signed product: extend first so the low 2*DATA_W bits are exact.
  always_comb begin
    w_a_ext = (2*DATA_W)'(r_s1_a);
    w_b_ext = (2*DATA_W)'(r_s1_b);
    w_prod  = w_a_ext * w_b_ext;
  end

  // S1/S2 pipeline registers; a last flag only survives alongside its valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_a     <= {DATA_W{1'b0}};
      r_s1_b     <= {DATA_W{1'b0}};
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_p     <= {(2*DATA_W){1'b0}};
    end else if (i_clr) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
    end else begin
      r_s1_valid <= i_valid;
      r_s1_last  <= i_valid & i_last;
      r_s1_a     <= i_a;
      r_s1_b     <= i_b;
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_valid & r_s1_last;
      r_s2_p     <= w_prod;
    end
  end

  assign o_valid = r_s2_valid;
  assign o_last  = r_s2_last;
  assign o_p     = r_s2_p;

endmodule

// File: rtl/mac_dot_product.sv
// -----------------------------------------------------------------------------
// mac_dot_product
// Pipelined signed multiply-accumulate: sums A*B over a vector delimited by
// IN_LAST and emits the requantized (shift / round / saturate) dot product.
//   CLK, RST (sync, active high), CLR (sync abort of current accumulation)
//   IN_VALID, IN_LAST, A, B : operand stream, one pair per cycle, no stall
//   OUT_VALID               : one-cycle pulse per completed vector
//   OUT_DATA, OUT_SAT       : result and clamp flag, held until next pulse
// Latency: three edges from the pair carrying IN_LAST being presented.
// -----------------------------------------------------------------------------
module mac_dot_product
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ACC_W    = DEF_ACC_W,
  parameter int unsigned OUT_W    = DEF_OUT_W,
  parameter int unsigned SHIFT    = DEF_SHIFT,
  parameter int unsigned ROUND    = DEF_ROUND,
  parameter int unsigned SATURATE = DEF_SATURATE
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CLR,
  input  logic                     IN_VALID,
  input  logic                     IN_LAST,
  input  logic signed [DATA_W-1:0] A,
  input  logic signed [DATA_W-1:0] B,
  output logic                     OUT_VALID,
  output logic signed [OUT_W-1:0]  OUT_DATA,
  output logic                     OUT_SAT
);

  logic                       w_s2_valid;
  logic                       w_s2_last;
  logic signed [2*DATA_W-1:0] w_s2_p;

  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_first;
  logic                       r_out_valid;
  logic signed [OUT_W-1:0]    r_out_data;
  logic                       r_out_sat;

  logic signed [ACC_W-1:0]    w_p_ext;
  logic signed [ACC_W-1:0]    w_acc_base;
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [PKG_W-1:0]    w_shifted;
  sat_res_t                   w_sat_res;
  logic signed [OUT_W-1:0]    w_q_data;
  logic                       w_q_sat;

  mac_mult_stage #(
    .DATA_W (DATA_W)
  ) u_mult (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_clr   (CLR),
    .i_valid (IN_VALID),
    .i_last  (IN_LAST),
    .i_a     (A),
    .i_b     (B),
    .o_valid (w_s2_valid),
    .o_last  (w_s2_last),
    .o_p     (w_s2_p)
  );

  // Running sum plus requantization of it. The first pair of a vector ignores
  // r_acc, so a new vector can start right after a LAST without a bubble.
  always_comb begin
    w_p_ext = ACC_W'(w_s2_p);
    if (r_first) begin
      w_acc_base = {ACC_W{1'b0}};
    end else begin
      w_acc_base = r_acc;
    end
    w_sum     = w_acc_base + w_p_ext;
    w_shifted = round_shift(PKG_W'(w_sum), SHIFT, (ROUND != 32'd0));
    w_sat_res = sat_shift(PKG_W'(w_sum), SHIFT, (ROUND != 32'd0), OUT_W);
    if (SATURATE != 32'd0) begin
      w_q_data = OUT_W'(w_sat_res.data);
      w_q_sat  = w_sat_res.sat;
    end else begin
      w_q_data = OUT_W'(w_shifted);
      w_q_sat  = 1'b0;
    end
  end

  // S3: accumulate, and on the last pair publish the result and rearm.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_acc       <= {ACC_W{1'b0}};
      r_first     <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= {OUT_W{1'b0}};
      r_out_sat   <= 1'b0;
    end else if (CLR) begin
      r_acc       <= {ACC_W{1'b0}};
      r_first     <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (w_s2_valid) begin
      if (w_s2_last) begin
        r_acc       <= {ACC_W{1'b0}};
        r_first     <= 1'b1;
        r_out_valid <= 1'b1;
        r_out_data  <= w_q_data;
        r_out_sat   <= w_q_sat;
      end else begin
        r_acc       <= w_sum;
        r_first     <= 1'b0;
        r_out_valid <= 1'b0;
      end
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign OUT_VALID = r_out_valid;
  assign OUT_DATA  = r_out_data;
  assign OUT_SAT   = r_out_sat;

endmodule

// File: tb/tb_mac_dot_product.sv
// -----------------------------------------------------------------------------
// tb_mac_dot_product
// Five parameterisations share one stimulus stream: defaults, 8-bit saturate,
// 8-bit wrap, SHIFT=4 with rounding, SHIFT=4 truncating. Expected results are
// pushed when a LAST pair is driven and popped on the cycle they are due.
// -----------------------------------------------------------------------------
module tb_mac_dot_product;

  logic              CLK = 1'b0;
  logic              RST;
  logic              CLR;
  logic              IN_VALID;
  logic              IN_LAST;
  logic signed [7:0] A;
  logic signed [7:0] B;

  logic              ov_def, os_def;
  logic signed [15:0] od_def;
  logic              ov_s8, os_s8;
  logic signed [7:0] od_s8;
  logic              ov_w8, os_w8;
  logic signed [7:0] od_w8;
  logic              ov_r4, os_r4;
  logic signed [15:0] od_r4;
  logic              ov_t4, os_t4;
  logic signed [15:0] od_t4;

  typedef struct {
    int     due;
    longint d_def, d_s8, d_w8, d_r4, d_t4;
    bit     s_def, s_s8, s_w8, s_r4, s_t4;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  bit     exp_v;
  bit     mon_en = 1'b0;
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  longint acc = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  mac_dot_product u_def (
    .CLK(CLK), .RST(RST), .CLR(CLR), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST),
    .A(A), .B(B), .OUT_VALID(ov_def), .OUT_DATA(od_def), .OUT_SAT(os_def));

  mac_dot_product #(.OUT_W(8), .SATURATE(1)) u_s8 (
    .CLK(CLK), .RST(RST), .CLR(CLR), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST),
    .A(A), .B(B), .OUT_VALID(ov_s8), .OUT_DATA(od_s8), .OUT_SAT(os_s8));

  mac_dot_product #(.OUT_W(8), .SATURATE(0)) u_w8 (
    .CLK(CLK), .RST(RST), .CLR(CLR), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST),
    .A(A), .B(B), .OUT_VALID(ov_w8), .OUT_DATA(od_w8), .OUT_SAT(os_w8));

  mac_dot_product #(.SHIFT(4), .ROUND(1)) u_r4 (
    .CLK(CLK), .RST(RST), .CLR(CLR), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST),
    .A(A), .B(B), .OUT_VALID(ov_r4), .OUT_DATA(od_r4), .OUT_SAT(os_r4));

  mac_dot_product #(.SHIFT(4), .ROUND(0)) u_t4 (
    .CLK(CLK), .RST(RST), .CLR(CLR), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST),
    .A(A), .B(B), .OUT_VALID(ov_t4), .OUT_DATA(od_t4), .OUT_SAT(os_t4));

  // Reference requantizer written directly from the arithmetic definition.
  function automatic longint model_q(input longint sum, input int shift, input bit rnd,
                                     input bit sat, input int out_w, output bit satf);
    longint r, s, hi, lo, m, span;
    r = sum;
    if (rnd && shift > 0) r = r + (longint'(1) << (shift - 1));
    s    = r >>> shift;
    span = longint'(1) << out_w;
    hi   = (span / 2) - 1;
    lo   = -(span / 2);
    satf = 1'b0;
    if (sat) begin
      if (s > hi) begin satf = 1'b1; return hi; end
      if (s < lo) begin satf = 1'b1; return lo; end
      return s;
    end
    m = s & (span - 1);
    if (m > hi) m = m - span;
    return m;
  endfunction

  // 24-bit two's complement wrap of the accumulator.
  function automatic longint wrap24(input longint v);
    longint m;
    m = v & 64'h0000_0000_00FF_FFFF;
    if (m >= 64'sh80_0000) m = m - 64'sh100_0000;
    return m;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus and update the reference accumulation.
  task automatic step(input bit v, input bit l, input int a, input int b,
                      input bit clr, input bit rst);
    exp_t e;
    bit   f;
    @(negedge CLK);
    IN_VALID = v;
    IN_LAST  = l;
    A        = 8'(a);
    B        = 8'(b);
    CLR      = clr;
    RST      = rst;
    if (rst || clr) begin
      acc = 0;
    end else if (v) begin
      acc = wrap24(acc + longint'(a) * longint'(b));
      if (l) begin
        e.due   = cyc + 3;
        e.d_def = model_q(acc, 0, 1'b0, 1'b1, 16, f); e.s_def = f;
        e.d_s8  = model_q(acc, 0, 1'b0, 1'b1, 8, f);  e.s_s8  = f;
        e.d_w8  = model_q(acc, 0, 1'b0, 1'b0, 8, f);  e.s_w8  = f;
        e.d_r4  = model_q(acc, 4, 1'b1, 1'b1, 16, f); e.s_r4  = f;
        e.d_t4  = model_q(acc, 4, 1'b0, 1'b1, 16, f); e.s_t4  = f;
        sb.push_back(e);
        acc = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // All outputs of every instance must read zero while reset is held.
  task automatic reset_check(input string tag);
    @(negedge CLK);
    chk({tag, "_def_v"}, 64'(ov_def), 64'sd0);
    chk({tag, "_def_d"}, 64'(od_def), 64'sd0);
    chk({tag, "_def_s"}, 64'(os_def), 64'sd0);
    chk({tag, "_s8_d"},  64'(od_s8),  64'sd0);
    chk({tag, "_s8_s"},  64'(os_s8),  64'sd0);
    chk({tag, "_r4_d"},  64'(od_r4),  64'sd0);
  endtask

  // Scoreboard monitor: valid must match the schedule; data checked when due.
  always @(negedge CLK) begin
    if (mon_en) begin
      exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      chk("def_valid", 64'(ov_def), 64'(exp_v));
      chk("s8_valid",  64'(ov_s8),  64'(exp_v));
      chk("w8_valid",  64'(ov_w8),  64'(exp_v));
      chk("r4_valid",  64'(ov_r4),  64'(exp_v));
      chk("t4_valid",  64'(ov_t4),  64'(exp_v));
      if (exp_v) begin
        mon_e = sb.pop_front();
        chk("def_data", 64'(od_def), mon_e.d_def);
        chk("def_sat",  64'(os_def), 64'(mon_e.s_def));
        chk("s8_data",  64'(od_s8),  mon_e.d_s8);
        chk("s8_sat",   64'(os_s8),  64'(mon_e.s_s8));
        chk("w8_data",  64'(od_w8),  mon_e.d_w8);
        chk("w8_sat",   64'(os_w8),  64'(mon_e.s_w8));
        chk("r4_data",  64'(od_r4),  mon_e.d_r4);
        chk("r4_sat",   64'(os_r4),  64'(mon_e.s_r4));
        chk("t4_data",  64'(od_t4),  mon_e.d_t4);
        chk("t4_sat",   64'(os_t4),  64'(mon_e.s_t4));
      end
    end
  end

  initial begin
    RST = 1'b1; CLR = 1'b0; IN_VALID = 1'b0; IN_LAST = 1'b0; A = 8'sd0; B = 8'sd0;
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    reset_check("rst_init");
    mon_en = 1'b1;
    idle(1);

    // Single pair: -1200
    step(1'b1, 1'b1, -30, 40, 1'b0, 1'b0);
    idle(4);

    // Three-term vector with a stray IN_LAST while IN_VALID=0: -2400
    step(1'b1, 1'b0, -30, 40, 1'b0, 1'b0);
    step(1'b0, 1'b1, 99, 99, 1'b0, 1'b0);
    step(1'b1, 1'b0, -20, 40, 1'b0, 1'b0);
    step(1'b1, 1'b1, -10, 40, 1'b0, 1'b0);
    idle(4);

    // Extremes on consecutive cycles: 16384 then -128
    step(1'b1, 1'b1, -128, -128, 1'b0, 1'b0);
    step(1'b1, 1'b1, -128, 1, 1'b0, 1'b0);
    idle(4);

    // Rounding around a shift of 4: 39 and -39
    step(1'b1, 1'b1, 3, 13, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 1'b1, -3, 13, 1'b0, 1'b0);
    idle(4);

    // Back-to-back vectors: 25 then 10
    step(1'b1, 1'b1, 5, 5, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2, 3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4, 1, 1'b0, 1'b0);
    idle(4);

    // 65536 clamps even the 16-bit instances
    repeat (3) step(1'b1, 1'b0, -128, -128, 1'b0, 1'b0);
    step(1'b1, 1'b1, -128, -128, 1'b0, 1'b0);
    idle(4);

    // CLR mid-vector (the pair alongside CLR is dropped), then 49
    step(1'b1, 1'b0, 11, 11, 1'b0, 1'b0);
    step(1'b1, 1'b0, 12, 12, 1'b0, 1'b0);
    step(1'b1, 1'b0, 9, 9, 1'b1, 1'b0);
    step(1'b1, 1'b1, 7, 7, 1'b0, 1'b0);
    idle(4);

    // Same with RST, checking outputs are zero during reset
    step(1'b1, 1'b0, 11, 11, 1'b0, 1'b0);
    step(1'b1, 1'b0, 12, 12, 1'b0, 1'b0);
    step(1'b1, 1'b0, 9, 9, 1'b0, 1'b1);
    reset_check("rst_mid");
    idle(1);
    step(1'b1, 1'b1, 7, 7, 1'b0, 1'b0);
    idle(5);

    chk("sb_drained", 64'(sb.size()), 64'sd0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_dot_product.md
Name: mac_dot_product

Overview:
- Parametrised, pipelined signed multiply-accumulate unit; successor to the fixed 8x8 signed multiplier wrapper.
- Accepts a stream of signed operand pairs and accumulates their products into a dot product. Typical use is one 3x3 kernel window per vector.
- On the last pair, emits the requantized result: arithmetic right shift, optional rounding, optional saturation.
- Sits between the window/weight fetch logic and the activation/pooling stage of the CNN datapath.

Parameters:
- DATA_W, 8, width of signed operands A and B.
- ACC_W, 24, signed accumulator width. Must be >= 2*DATA_W. Sized by the user for the maximum vector length.
- OUT_W, 16, width of signed OUT_DATA. Must be <= ACC_W.
- SHIFT, 0, arithmetic right shift applied to the final sum. Range 0..ACC_W-1.
- ROUND, 0, when 1 and SHIFT>0, add 2^(SHIFT-1) before shifting (round half up).
- SATURATE, 1, when 1 clamp to the OUT_W signed range; when 0 truncate to the low OUT_W bits.

Ports:
- CLK, in, 1, clock; all logic on the rising edge.
- RST, in, 1, synchronous active-high reset.
- CLR, in, 1, synchronous abort of the current accumulation.
- IN_VALID, in, 1, A/B/IN_LAST valid this cycle.
- IN_LAST, in, 1, marks the final pair of a vector.
- A, in, DATA_W, signed operand.
- B, in, DATA_W, signed operand.
- OUT_VALID, out, 1, one-cycle pulse: OUT_DATA/OUT_SAT valid.
- OUT_DATA, out, OUT_W, signed requantized dot product.
- OUT_SAT, out, 1, result was clamped; meaningful only with OUT_VALID.

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high.
- Reset: all pipeline valids, OUT_VALID, OUT_SAT and OUT_DATA go to 0; accumulator goes to 0; first flag goes to 1.
- No backpressure. An input is accepted on every edge where IN_VALID=1. Throughput is one pair per cycle.
- S1 (edge t+1): register A, B, IN_VALID, IN_LAST.
- S2 (edge t+2): full signed product P = A*B, 2*DATA_W bits. Register P with its valid and last flags.
- S3 (edge t+3), when s2_valid:
  - sum = (first ? 0 : acc) + sign_extend(P, ACC_W).
  - Accumulation wraps in two's complement; there is no internal overflow detection.
  - If s2_last: acc<=0, first<=1, OUT_VALID<=1, OUT_DATA<=requant(sum), OUT_SAT set per the clamp.
  - Otherwise: acc<=sum, first<=0, OUT_VALID<=0.
- Latency: the pair accepted with IN_LAST=1 at edge t produces OUT_VALID=1 at edge t+3.
- OUT_DATA holds its value until the next OUT_VALID. OUT_VALID never stays high for two cycles unless two vectors end on consecutive cycles.
- requant(sum):
  - r = sum + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0), computed at ACC_W+1 bits so it cannot overflow.
  - s = r >>> SHIFT.
  - SATURATE=1: clamp s to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; OUT_SAT=1 iff clamped.
  - SATURATE=0: OUT_DATA = s[OUT_W-1:0], OUT_SAT=0.
- Single-element vector (IN_LAST on the first pair) is legal; result = requant(P).
- Back-to-back vectors: a pair with IN_VALID=1 on the cycle after a LAST pair starts a new vector. There are no idle cycles and no carry-over.
- IN_LAST with IN_VALID=0 is ignored.
- CLR:
  - Clears the S1/S2 valid flags, acc<=0 and first<=1.
  - The pair presented in the same cycle as CLR is dropped.
  - OUT_VALID is forced to 0 on the following edge. OUT_DATA keeps its previous value.
- RST has priority over CLR. RST mid-vector discards all partial state; no OUT_VALID results from pairs in flight.

Decomposition:
- Package mac_pkg:
  - Default width constants.
  - Function sat_shift(value, shift, round, out_w) returning {sat_flag, data}, shared with future requantizers.
- One sub-module: mac_mult_stage, the S1/S2 registered signed multiplier with valid/last sidechain. It is replaceable by a DSP-inferred or IP multiplier.
- S3 and requantization are written inline.

Test Plan:
- Defaults. A=-30, B=40, IN_VALID=IN_LAST=1 at edge 0 → OUT_VALID pulse at edge 3, OUT_DATA=-1200, OUT_SAT=0.
- Three-term vector (-30,40), (-20,40), (-10,40), LAST on the third → OUT_DATA=-2400 three edges after the third pair; exactly one pulse.
- OUT_W=8, SATURATE=1: single pair (-128,-128) → OUT_DATA=127, OUT_SAT=1. Pair (-128,1) → -128, OUT_SAT=0. With SATURATE=0, (-128,-128) → 0.
- SHIFT=4, ROUND=1: (3,13) → 2; (-3,13) → -2. With ROUND=0: (3,13) → 2; (-3,13) → -3.
- Back-to-back vectors: [(5,5) LAST] then [(2,3),(4,1) LAST] on consecutive cycles → outputs 25 and 10, in order, with no contamination.
- CLR asserted after two pairs of a vector, then a fresh [(7,7) LAST] → only OUT_DATA=49. Repeat the same sequence with RST instead of CLR → same single result, and all outputs 0 during reset.
